// File: rtl/voting_session_pkg.sv
// voting_session_pkg: ballot FSM states and width helper shared by the voting session files
package voting_session_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, TALLY, DONE} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/voting_session_vote_popcount.sv
// vote_popcount: combinational count of set bits in an N-bit vote mask
module vote_popcount
  import voting_session_pkg::*;
#(
  parameter int N = 3,
  localparam int CW = clog2(N + 1)
) (
  input  logic [N-1:0]  v,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CW'(v[i]);
  end
endmodule

// File: rtl/voting_session.sv
// voting_session: collects one vote per voter per session and publishes registered tallies and rule flags
module voting_session
  import voting_session_pkg::*;
#(
  parameter int N_VOTERS = 3,
  parameter int TIMEOUT_CYC = 16,
  localparam int CNT_W = clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                open_i,
  input  logic                close_i,
  input  logic [N_VOTERS-1:0] vote_valid_i,
  input  logic [N_VOTERS-1:0] vote_yes_i,
  output logic                busy_o,
  output logic                result_valid_o,
  output logic [CNT_W-1:0]    yes_cnt_o,
  output logic [CNT_W-1:0]    no_cnt_o,
  output logic [CNT_W-1:0]    abst_cnt_o,
  output logic                unanimous_o,
  output logic                majority_o,
  output logic                any_yes_o,
  output logic                none_yes_o,
  output logic                tie_o
);
  localparam int TMR_W = TIMEOUT_CYC > 0 ? clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N_VOTERS);
  state_t state, state_n;
  logic [N_VOTERS-1:0] voted, acc, voted_n;
  logic [CNT_W-1:0] yes_c, no_c, acc_yes, acc_no, yes_n, no_n;
  logic [TMR_W-1:0] timer;
  logic close, timeout, opening;
  assign acc = state == OPEN ? vote_valid_i & ~voted : '0;
  assign voted_n = voted | acc;
  vote_popcount #(.N(N_VOTERS)) u_pc_yes (.v(acc & vote_yes_i), .cnt(acc_yes));
  vote_popcount #(.N(N_VOTERS)) u_pc_no (.v(acc & ~vote_yes_i), .cnt(acc_no));
  assign yes_n = yes_c + acc_yes;
  assign no_n = no_c + acc_no;
  assign timeout = TIMEOUT_CYC != 0 && timer == TMR_W'(TIMEOUT_CYC - 1);
  assign close = &voted_n || close_i || timeout;
  assign opening = (state == IDLE || state == DONE) && open_i;
  assign busy_o = state == OPEN || state == TALLY;
  always_comb begin
    state_n = state;
    state_n = opening ? OPEN :
              state == OPEN ? (close ? TALLY : OPEN) :
              state == TALLY ? DONE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // working counters restart on open; published outputs only change in TALLY
  always_ff @(posedge clk) begin
    if (rst) begin
      voted <= '0;
      yes_c <= '0;
      no_c <= '0;
      timer <= '0;
      result_valid_o <= 1'b0;
      yes_cnt_o <= '0;
      no_cnt_o <= '0;
      abst_cnt_o <= '0;
      unanimous_o <= 1'b0;
      majority_o <= 1'b0;
      any_yes_o <= 1'b0;
      none_yes_o <= 1'b0;
      tie_o <= 1'b0;
    end else begin
      result_valid_o <= state == TALLY;
      if (opening) begin
        voted <= '0;
        yes_c <= '0;
        no_c <= '0;
        timer <= '0;
      end else if (state == OPEN) begin
        voted <= voted_n;
        yes_c <= yes_n;
        no_c <= no_n;
        timer <= timer + TMR_W'(1);
      end
      if (state == TALLY) begin
        yes_cnt_o <= yes_c;
        no_cnt_o <= no_c;
        abst_cnt_o <= N_C - yes_c - no_c;
        unanimous_o <= yes_c == N_C;
        majority_o <= {yes_c, 1'b0} > {1'b0, N_C};
        any_yes_o <= yes_c != '0;
        none_yes_o <= yes_c == '0;
        tie_o <= yes_c == no_c && yes_c != '0;
      end
    end
  end
endmodule

// File: tb/tb_voting_session.sv
// tb_voting_session: directed table-driven and sequence checks of voting_session with 3 and 4 voters
module tb_voting_session;
  logic clk = 1'b0, rst = 1'b1;
  logic open3 = 1'b0, close3 = 1'b0, open4 = 1'b0, close4 = 1'b0;
  logic [2:0] vv3 = '0, vy3 = '0;
  logic [3:0] vv4 = '0, vy4 = '0;
  logic busy3, rv3, un3, mj3, any3, none3, tie3;
  logic busy4, rv4, un4, mj4, any4, none4, tie4;
  logic [1:0] y3, n3, a3;
  logic [2:0] y4, n4, a4;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [2:0] pat;
    int y, n;
    bit un, mj, an, no;
  } vec_t;
  vec_t tbl[8];
  voting_session #(.N_VOTERS(3), .TIMEOUT_CYC(16)) dut3 (
    .clk(clk), .rst(rst), .open_i(open3), .close_i(close3),
    .vote_valid_i(vv3), .vote_yes_i(vy3), .busy_o(busy3), .result_valid_o(rv3),
    .yes_cnt_o(y3), .no_cnt_o(n3), .abst_cnt_o(a3), .unanimous_o(un3),
    .majority_o(mj3), .any_yes_o(any3), .none_yes_o(none3), .tie_o(tie3)
  );
  voting_session #(.N_VOTERS(4), .TIMEOUT_CYC(16)) dut4 (
    .clk(clk), .rst(rst), .open_i(open4), .close_i(close4),
    .vote_valid_i(vv4), .vote_yes_i(vy4), .busy_o(busy4), .result_valid_o(rv4),
    .yes_cnt_o(y4), .no_cnt_o(n4), .abst_cnt_o(a4), .unanimous_o(un4),
    .majority_o(mj4), .any_yes_o(any4), .none_yes_o(none4), .tie_o(tie4)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_rv(input bit four, input int budget, output int cyc);
    cyc = 0;
    while (!(four ? rv4 : rv3) && cyc < budget) begin
      step();
      cyc++;
    end
    chk("rv_seen", int'(four ? rv4 : rv3), 1);
  endtask
  task automatic res(input bit four, input string nm, input int y, input int n, input int a,
                     input bit un, input bit mj, input bit an, input bit no, input bit ti);
    chk({nm, "_yes"}, four ? int'(y4) : int'(y3), y);
    chk({nm, "_no"}, four ? int'(n4) : int'(n3), n);
    chk({nm, "_abst"}, four ? int'(a4) : int'(a3), a);
    chk({nm, "_unan"}, int'(four ? un4 : un3), int'(un));
    chk({nm, "_maj"}, int'(four ? mj4 : mj3), int'(mj));
    chk({nm, "_any"}, int'(four ? any4 : any3), int'(an));
    chk({nm, "_none"}, int'(four ? none4 : none3), int'(no));
    chk({nm, "_tie"}, int'(four ? tie4 : tie3), int'(ti));
  endtask
  task automatic open3_s();
    open3 = 1'b1;
    step();
    open3 = 1'b0;
  endtask
  task automatic open4_s();
    open4 = 1'b1;
    step();
    open4 = 1'b0;
  endtask
  initial begin
    int cyc;
    tbl[0] = '{3'b000, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'b001, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{3'b010, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'b011, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{3'b100, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{3'b101, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{3'b110, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{3'b111, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    step();
    step();
    chk("rst_busy", int'(busy3), 0);
    chk("rst_rv", int'(rv3), 0);
    res(1'b0, "rst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_yes4", int'(y4), 0);
    rst = 1'b0;
    close3 = 1'b1;
    step();
    close3 = 1'b0;
    chk("idle_close_busy", int'(busy3), 0);
    for (int i = 0; i < 8; i++) begin
      open3_s();
      chk($sformatf("tt%0d_busy_open", i), int'(busy3), 1);
      vv3 = 3'b111;
      vy3 = tbl[i].pat;
      step();
      vv3 = '0;
      vy3 = '0;
      chk($sformatf("tt%0d_busy_tally", i), int'(busy3), 1);
      chk($sformatf("tt%0d_rv_early", i), int'(rv3), 0);
      wait_rv(1'b0, 4, cyc);
      chk($sformatf("tt%0d_lat", i), cyc, 1);
      res(1'b0, $sformatf("tt%0d", i), tbl[i].y, tbl[i].n, 0, tbl[i].un, tbl[i].mj,
          tbl[i].an, tbl[i].no, 1'b0);
      step();
      chk($sformatf("tt%0d_rv_pulse", i), int'(rv3), 0);
      chk($sformatf("tt%0d_busy_done", i), int'(busy3), 0);
    end
    open3_s();
    for (int c = 1; c <= 7; c++) begin
      vv3 = c == 1 ? 3'b001 : c == 4 ? 3'b100 : c == 7 ? 3'b010 : 3'b000;
      vy3 = vv3;
      step();
    end
    vv3 = '0;
    vy3 = '0;
    chk("stag_rv_t1", int'(rv3), 0);
    chk("stag_busy_t1", int'(busy3), 1);
    step();
    chk("stag_rv_t2", int'(rv3), 1);
    res(1'b0, "stag", 3, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("stag_rv_drop", int'(rv3), 0);
    chk("stag_hold", int'(y3), 3);
    open3_s();
    vv3 = 3'b001;
    vy3 = 3'b001;
    step();
    vy3 = 3'b000;
    step();
    vv3 = '0;
    close3 = 1'b1;
    step();
    close3 = 1'b0;
    wait_rv(1'b0, 4, cyc);
    chk("dup_lat", cyc, 1);
    res(1'b0, "dup", 1, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    open3_s();
    chk("held_prev_yes", int'(y3), 1);
    chk("held_prev_abst", int'(a3), 2);
    vv3 = 3'b010;
    vy3 = 3'b000;
    step();
    vv3 = '0;
    wait_rv(1'b0, 40, cyc);
    chk("timeout_lat", cyc, 16);
    res(1'b0, "tmo", 0, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    close3 = 1'b1;
    step();
    close3 = 1'b0;
    chk("done_close_busy", int'(busy3), 0);
    chk("done_close_rv", int'(rv3), 0);
    open3_s();
    vv3 = 3'b011;
    vy3 = 3'b011;
    step();
    vv3 = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(busy3), 0);
    chk("abort_rv", int'(rv3), 0);
    res(1'b0, "abort", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort_no_pulse%0d", k), int'(rv3), 0);
    end
    open3_s();
    vv3 = 3'b100;
    vy3 = 3'b100;
    close3 = 1'b1;
    step();
    vv3 = '0;
    vy3 = '0;
    close3 = 1'b0;
    wait_rv(1'b0, 4, cyc);
    res(1'b0, "post_abort", 1, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    open4_s();
    vv4 = 4'b1111;
    vy4 = 4'b0011;
    step();
    vv4 = '0;
    vy4 = '0;
    wait_rv(1'b1, 4, cyc);
    chk("n4_tie_lat", cyc, 1);
    res(1'b1, "n4_tie", 2, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    open4_s();
    vv4 = 4'b0001;
    vy4 = 4'b0001;
    step();
    vv4 = 4'b0010;
    vy4 = 4'b0000;
    close4 = 1'b1;
    step();
    vv4 = '0;
    close4 = 1'b0;
    wait_rv(1'b1, 4, cyc);
    chk("n4_close_lat", cyc, 1);
    res(1'b1, "n4_close", 1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    open4_s();
    vv4 = 4'b0111;
    vy4 = 4'b0111;
    close4 = 1'b1;
    step();
    vv4 = '0;
    vy4 = '0;
    close4 = 1'b0;
    wait_rv(1'b1, 4, cyc);
    res(1'b1, "n4_maj", 3, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
